// File: rtl/usr_seq_ctrl.sv
// Command sequencer for a universal shift register: accepts load/shift/rotate
// commands over valid/ready and drives select/serial lines for the needed cycles.
module usr_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    output logic [1:0]       usr_select,
    output logic [WIDTH-1:0] usr_p_din,
    output logic             usr_s_right_din,
    output logic             usr_s_left_din,
    input  logic             usr_s_right_dout,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROR  = 2'b11;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SR   = 2'b01;
    localparam logic [1:0] SEL_SL   = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    logic [1:0]       r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_rem;
    logic             r_fill;
    logic             w_accept;

    assign w_accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_data  <= '0;
            r_rem   <= '0;
            r_fill  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= cmd_op;
                        r_data <= cmd_data;
                        r_rem  <= cmd_count;
                        r_fill <= cmd_fill;
                        if (cmd_op == OP_LOAD)
                            r_state <= S_LOAD;
                        else if (cmd_count == '0)
                            r_state <= S_DONE;
                        else
                            r_state <= S_SHIFT;
                    end
                end
                S_LOAD:  r_state <= S_DONE;
                S_SHIFT: begin
                    r_rem <= r_rem - 1'b1;
                    if (r_rem == CNT_W'(1))
                        r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign usr_p_din = r_data;

    // Rotate feeds the register's LSB straight back into its MSB serial input.
    always_comb begin
        usr_select      = SEL_HOLD;
        usr_s_right_din = 1'b0;
        usr_s_left_din  = 1'b0;
        case (r_state)
            S_LOAD:  usr_select = SEL_LOAD;
            S_SHIFT: begin
                case (r_op)
                    OP_SHR: begin
                        usr_select      = SEL_SR;
                        usr_s_right_din = r_fill;
                    end
                    OP_ROR: begin
                        usr_select      = SEL_SR;
                        usr_s_right_din = usr_s_right_dout;
                    end
                    OP_SHL: begin
                        usr_select     = SEL_SL;
                        usr_s_left_din = r_fill;
                    end
                    default: usr_select = SEL_HOLD;
                endcase
            end
            default: usr_select = SEL_HOLD;
        endcase
    end

endmodule

// File: doc/usr_seq_ctrl.md
# usr_seq_ctrl

Command sequencer for a 4-bit-class universal shift register (select encoding: 00 hold, 01 shift right, 10 shift left, 11 parallel load). It accepts load, shift and rotate commands over a valid/ready handshake. It then drives the register's select, parallel and serial inputs for the required number of cycles and pulses done when the operation has fully landed. It sits between a host or FSM issuing bit-manipulation commands and the shift-register datapath, so that no requester drives the register's select lines directly.

## Interface
- WIDTH, 4, width of the controlled shift register.
- CNT_W, 3, width of shift/rotate count (max count 2^CNT_W-1).
- clk  in  1  rising-edge clock, shared with the shift register.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 load, 01 shift right, 10 shift left, 11 rotate right.
- cmd_data  in  WIDTH  parallel value for load.
- cmd_count  in  CNT_W  number of shift/rotate steps.
- cmd_fill  in  1  serial fill bit for shift right/left.
- usr_select  out  2  to register select.
- usr_p_din  out  WIDTH  to register parallel input.
- usr_s_right_din  out  1  to register MSB serial input (used on right shift).
- usr_s_left_din  out  1  to register LSB serial input (used on left shift).
- usr_s_right_dout  in  1  register LSB (p_dout[0]), used for rotate.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, SHIFT, DONE. State, op, data, count and fill latches are registered. All outputs decode combinationally from the state and the latches.
- IDLE:
  - cmd_ready=1, usr_select=00.
  - On cmd_valid&&cmd_ready, latch op/data/count/fill.
  - Next state: op 00 → LOAD; op≠00 with count≠0 → SHIFT with remaining=count; op≠00 with count=0 → DONE.
- LOAD: usr_select=11, usr_p_din=latched data, for exactly one cycle → DONE.
- SHIFT:
  - usr_select=01 for op 01 and op 11; usr_select=10 for op 10.
  - remaining decrements by 1 every cycle.
  - When remaining==1 this cycle, next state is DONE. Exactly `count` cycles are spent in SHIFT.
- Serial drive:
  - In SHIFT with op 01: usr_s_right_din=fill.
  - In SHIFT with op 11: usr_s_right_din=usr_s_right_dout (combinational pass-through gives a rotate right).
  - In SHIFT with op 10: usr_s_left_din=fill.
  - All other cases: both serial outputs are 0.
- DONE: done=1, usr_select=00, for one cycle → IDLE.
- usr_p_din is the latched data in every state; it only has effect while usr_select=11.
- cmd_ready=0 in LOAD/SHIFT/DONE. cmd_valid is ignored there and the command is not latched.
- No rotate-left op. The count is not reduced modulo WIDTH: rotate by WIDTH returns the original value after WIDTH cycles.

## Timing
- Reset (rst=0, asynchronous):
  - State goes to IDLE immediately; latches are cleared.
  - Outputs: cmd_ready=1, usr_select=00, usr_p_din=0, both serial outputs 0, busy=0, done=0.
- Reset mid-operation aborts the command with no done pulse. Register contents are left as already shifted.
- Accept at edge E0.
  - Load: usr_select=11 during cycle E0–E1, done high during E1–E2.
  - Shift/rotate of N: select active for cycles E0 through E0+N, done high in the following cycle.
  - Count 0: done high during E0–E1 and no select activity.
- Accept-to-done-edge latency:
  - load: 2 cycles;
  - shift/rotate N: N+1 cycles;
  - count 0: 1 cycle.
- Back-to-back: the next accept is earliest at the edge ending the IDLE cycle after DONE. That gives a minimum issue interval of load 3 cycles and shift N+2 cycles.
- The register reflects the final value at the edge that enters DONE, so it is valid while done=1.

## Test plan
Each scenario runs against a behavioural model of the register, WIDTH=4.

- Load 4'b1011 → usr_select=11 for exactly 1 cycle with usr_p_din=1011, then done pulse; register=1011 while done=1.
- From 1011, shift right, count 2, fill 1 → usr_select=01 for 2 cycles, register 1101 then 1110, then done.
- From 1011, shift left, count 3, fill 0 → usr_select=10 for 3 cycles, register 0110, 1100, 1000, then done.
- From 1011, rotate right, count 5 → register 1101, 1110, 0111, 1011, 1101; done on the 6th cycle after accept.
- Shift with count 0 → done the cycle after accept, usr_select stays 00. Also hold cmd_valid high while busy: no second accept until cmd_ready=1.
- Assert rst=0 mid-SHIFT with 3 steps remaining → same cycle usr_select=00, busy=0, cmd_ready=1, and no done pulse. After release, a new load is accepted normally.
